// File: rtl/zigzag_encoder_pkg.sv
// Shared JPEG package (also used by zigzag_decoder). It holds the coefficient
// type, the encoder FSM states and the zigzag-index to raster-position table.
package zigzag_encoder_pkg;

   localparam int COEFF_W_DEFAULT = 12;

   typedef logic signed [COEFF_W_DEFAULT-1:0] coeff_t;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      SCAN = 2'd1,
      EOB  = 2'd2
   } state_t;

   // Entry i is the raster position (row*8 + col) of zigzag index i.
   localparam logic [5:0] ZZ_TABLE [64] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   function automatic logic [5:0] zz_pos(input logic [5:0] index);
      return ZZ_TABLE[index];
   endfunction

endpackage

// File: rtl/zigzag_encoder_if.sv
// Column input stream and (run, value) pair output stream of the zigzag
// encoder. The master side feeds columns and sinks pairs; the encoder is the slave.
interface zigzag_encoder_if
   import zigzag_encoder_pkg::*;
#(
   parameter int COEFF_W = COEFF_W_DEFAULT
);

   logic [8*COEFF_W-1:0]      column;
   logic                      column_valid;
   logic                      column_ready;
   logic signed [COEFF_W-1:0] value;
   logic [5:0]                run;
   logic                      dc;
   logic                      eob;
   logic                      pair_valid;
   logic                      pair_ready;

   modport master (
      output column, column_valid, pair_ready,
      input  column_ready, value, run, dc, eob, pair_valid
   );

   modport slave (
      input  column, column_valid, pair_ready,
      output column_ready, value, run, dc, eob, pair_valid
   );

endinterface

// File: rtl/zigzag_encoder_lut.sv
// Combinational zigzag index to (row, column) mapping.
module zigzag_lut
   import zigzag_encoder_pkg::*;
(
   input  logic [5:0] index,
   output logic [2:0] row,
   output logic [2:0] col
);

   assign {row, col} = zz_pos(index);

endmodule

// File: rtl/zigzag_encoder.sv
// 8x8 block zigzag run-length encoder: columns in, (run, value) pairs out.
// Define ZIGZAG_ENCODER_DOUBLE_BUFFER_EN for ping-pong buffers so filling overlaps scanning.
module zigzag_encoder
   import zigzag_encoder_pkg::*;
#(
   parameter int COEFF_W = COEFF_W_DEFAULT
)
(
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic [8*COEFF_W-1:0]      column_in,
   input  logic                      valid_in,
   output logic                      ready_out,
   output logic signed [COEFF_W-1:0] value_out,
   output logic [5:0]                run_out,
   output logic                      dc_out,
   output logic                      eob_out,
   output logic                      valid_out,
   input  logic                      ready_in
);

   state_t                    state, state_next;
   logic [2:0]                col_cnt;
   logic [5:0]                idx;
   logic [5:0]                run;
   logic                      accept, accept_last;
   logic [2:0]                zz_row, zz_col;
   logic signed [COEFF_W-1:0] coeff;
   logic                      coeff_nz;
   logic                      block_avail;
   logic                      next_avail;
   logic                      advance;
   logic                      scan_done;

   assign accept      = valid_in && ready_out;
   assign accept_last = accept && (col_cnt == 3'd7);
   assign coeff_nz    = (coeff != '0);

   zigzag_lut u_lut (
      .index (idx),
      .row   (zz_row),
      .col   (zz_col)
   );

   always_ff @(posedge clk_in) begin
      if (rst_in)
         col_cnt <= 3'd0;
      else if (accept)
         col_cnt <= col_cnt + 3'd1;
   end

`ifdef ZIGZAG_ENCODER_DOUBLE_BUFFER_EN
   logic signed [COEFF_W-1:0] mem [2][64];
   logic                      fill_bank;
   logic                      scan_bank;
   logic [1:0]                full;

   assign ready_out   = !full[fill_bank];
   // A bank completing this very cycle counts as available, so the scan starts next cycle.
   assign block_avail = full[scan_bank]  || (accept_last && (fill_bank == scan_bank));
   assign next_avail  = full[!scan_bank] || (accept_last && (fill_bank != scan_bank));
   assign coeff       = mem[scan_bank][{zz_row, zz_col}];

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         fill_bank <= 1'b0;
         scan_bank <= 1'b0;
         full      <= 2'b00;
      end else begin
         if (accept_last) begin
            full[fill_bank] <= 1'b1;
            fill_bank       <= !fill_bank;
         end
         if (scan_done) begin
            full[scan_bank] <= 1'b0;
            scan_bank       <= !scan_bank;
         end
      end
   end

   // NOTE: the block storage has no reset; valid data is gated by the full flags and FSM.
   always_ff @(posedge clk_in) begin
      if (accept) begin
         for (int r = 0; r < 8; r++)
            mem[fill_bank][{3'(r), col_cnt}] <= column_in[COEFF_W*r +: COEFF_W];
      end
   end
`else
   logic signed [COEFF_W-1:0] mem [64];

   assign ready_out   = (state == FILL);
   assign block_avail = accept_last;
   assign next_avail  = 1'b0;
   assign coeff       = mem[{zz_row, zz_col}];

   // NOTE: the block storage has no reset; valid data is gated by the FSM.
   always_ff @(posedge clk_in) begin
      if (accept) begin
         for (int r = 0; r < 8; r++)
            mem[{3'(r), col_cnt}] <= column_in[COEFF_W*r +: COEFF_W];
      end
   end
`endif

   always_ff @(posedge clk_in) begin
      if (rst_in)
         state <= FILL;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      valid_out  = 1'b0;
      value_out  = '0;
      run_out    = '0;
      dc_out     = 1'b0;
      eob_out    = 1'b0;
      advance    = 1'b0;
      scan_done  = 1'b0;
      unique case (state)
         FILL: begin
            if (block_avail)
               state_next = SCAN;
         end
         SCAN: begin
            valid_out = (idx == 6'd0) || coeff_nz;
            dc_out    = (idx == 6'd0);
            if (valid_out) begin
               value_out = coeff;
               run_out   = run;
            end
            // Zero coefficients never stall; a presented pair waits for ready_in.
            advance = !valid_out || ready_in;
            if (advance && (idx == 6'd63)) begin
               if (coeff_nz)
                  scan_done = 1'b1;
               else
                  state_next = EOB;
            end
         end
         EOB: begin
            valid_out = 1'b1;
            eob_out   = 1'b1;
            scan_done = ready_in;
         end
         default: state_next = FILL;
      endcase
      if (scan_done)
         state_next = next_avail ? SCAN : FILL;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         idx <= 6'd0;
         run <= 6'd0;
      end else if (state == SCAN) begin
         if (advance) begin
            idx <= idx + 6'd1;
            run <= valid_out ? 6'd0 : run + 6'd1;
         end
      end else begin
         idx <= 6'd0;
         run <= 6'd0;
      end
   end

endmodule

// File: tb/tb_zigzag_encoder.sv
// Scoreboard bench for zigzag_encoder: directed blocks with hand-computed pairs,
// a negedge monitor for pair order, stall holding, DC timing and ready_out behaviour.
`timescale 1ns/1ps
module tb_zigzag_encoder;
   import zigzag_encoder_pkg::*;

   localparam int W = COEFF_W_DEFAULT;

   typedef struct {
      coeff_t     value;
      logic [5:0] run;
      logic       dc;
      logic       eob;
      logic       last;
   } pair_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   zigzag_encoder_if #(.COEFF_W(W)) bus ();

   zigzag_encoder #(.COEFF_W(W)) dut (
      .clk_in    (clk),
      .rst_in    (rst),
      .column_in (bus.column),
      .valid_in  (bus.column_valid),
      .ready_out (bus.column_ready),
      .value_out (bus.value),
      .run_out   (bus.run),
      .dc_out    (bus.dc),
      .eob_out   (bus.eob),
      .valid_out (bus.pair_valid),
      .ready_in  (bus.pair_ready)
   );

   pair_t  sb[$];
   int     fill_q[$];
   int     compared   = 0;
   int     mismatched = 0;
   int     cyc        = 0;
   int     end_cyc    = -1;
   int     acc_cnt    = 0;
   logic   stalled    = 1'b0;
   pair_t  snap;
   coeff_t blk [64];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: sampled on the falling edge, half a cycle away from the active edge.
   always @(negedge clk) begin
      if (rst) begin
         acc_cnt = 0;
         fill_q.delete();
         end_cyc = -1;
         stalled = 1'b0;
      end else begin
         if (bus.column_valid && bus.column_ready) begin
            if (acc_cnt == 7) fill_q.push_back(cyc);
            acc_cnt = (acc_cnt + 1) % 8;
         end
         if (stalled) begin
            check("hold_valid", bus.pair_valid, 1'b1);
            check("hold_value", bus.value, snap.value);
            check("hold_run",   bus.run,   snap.run);
            check("hold_dc",    bus.dc,    snap.dc);
            check("hold_eob",   bus.eob,   snap.eob);
         end
         if (bus.pair_valid && bus.dc && !stalled) begin
            check("dc_fill_known", fill_q.size() != 0, 1'b1);
            if (fill_q.size() != 0) begin
               int f;
               f = fill_q.pop_front();
               check("dc_timing", cyc, ((f > end_cyc) ? f : end_cyc) + 1);
            end
         end
`ifndef ZIGZAG_ENCODER_DOUBLE_BUFFER_EN
         if (bus.pair_valid) check("ready_low_in_scan", bus.column_ready, 1'b0);
`endif
         if (bus.pair_valid && bus.pair_ready) begin
            check("pair_expected", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
               pair_t e;
               e = sb.pop_front();
               check("pair_value", bus.value, e.value);
               check("pair_run",   bus.run,   e.run);
               check("pair_dc",    bus.dc,    e.dc);
               check("pair_eob",   bus.eob,   e.eob);
               if (e.last) end_cyc = cyc;
            end
         end
         stalled    = bus.pair_valid && !bus.pair_ready;
         snap.value = bus.value;
         snap.run   = bus.run;
         snap.dc    = bus.dc;
         snap.eob   = bus.eob;
      end
   end

   function automatic logic [8*W-1:0] make_col(input int c);
      logic [8*W-1:0] col;
      for (int r = 0; r < 8; r++) col[W*r +: W] = blk[r*8 + c];
      return col;
   endfunction

   task automatic clear_blk();
      for (int i = 0; i < 64; i++) blk[i] = '0;
   endtask

   task automatic push(input int value, input int run, input bit dc, input bit eob, input bit last);
      pair_t p;
      p.value = coeff_t'(value);
      p.run   = 6'(run);
      p.dc    = dc;
      p.eob   = eob;
      p.last  = last;
      sb.push_back(p);
   endtask

   task automatic send_col(input logic [8*W-1:0] col);
      int  n = 0;
      logic timed_out = 1'b0;
      bus.column       = col;
      bus.column_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (bus.column_ready) break;
         n++;
         if (n > 500) begin timed_out = 1'b1; break; end
      end
      check("column_accept_timeout", timed_out, 1'b0);
      @(posedge clk);
      #1 bus.column_valid = 1'b0;
   endtask

   task automatic send_block();
      for (int c = 0; c < 8; c++) send_col(make_col(c));
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("drain_pending_pairs", sb.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid_out"}, bus.pair_valid,   1'b0);
      check({tag, "_ready_out"}, bus.column_ready, 1'b1);
      check({tag, "_value_out"}, bus.value,        '0);
      check({tag, "_run_out"},   bus.run,          '0);
      check({tag, "_dc_out"},    bus.dc,           1'b0);
      check({tag, "_eob_out"},   bus.eob,          1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.column       = '0;
      bus.column_valid = 1'b0;
      bus.pair_ready   = 1'b1;
      rst              = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk);
      #1 rst = 1'b0;

      // All-zero block: DC pair then EOB, then the output goes idle.
      clear_blk();
      push(0, 0, 1, 0, 0);
      push(0, 0, 0, 1, 1);
      send_block();
      wait_drain();
      check("idle_after_eob", bus.pair_valid, 1'b0);

      // DC 5 and [7][7] = -3: 62 skipped zeros, no EOB.
      clear_blk();
      blk[0]  = 12'sd5;
      blk[63] = -12'sd3;
      push(5, 0, 1, 0, 0);
      push(-3, 62, 0, 0, 1);
      send_block();
      wait_drain();
      check("idle_after_last", bus.pair_valid, 1'b0);

      // [0][1] is zigzag 1, [2][0] is zigzag 3 with one zero before it.
      clear_blk();
      blk[0]  = 12'sd1;
      blk[1]  = 12'sd2;
      blk[16] = -12'sd1;
      push(1, 0, 1, 0, 0);
      push(2, 0, 0, 0, 0);
      push(-1, 1, 0, 0, 0);
      push(0, 0, 0, 1, 1);
      send_block();
      wait_drain();

      // Dense start of block with ready_in 1-0-0-1 right after the DC pair.
      clear_blk();
      blk[0]  = 12'sd7;
      blk[1]  = -12'sd4;
      blk[8]  = 12'sd3;
      blk[16] = 12'sd9;
      blk[9]  = -12'sd8;
      push(7, 0, 1, 0, 0);
      push(-4, 0, 0, 0, 0);
      push(3, 0, 0, 0, 0);
      push(9, 0, 0, 0, 0);
      push(-8, 0, 0, 0, 0);
      push(0, 0, 0, 1, 1);
      send_block();
      @(posedge clk);
      #1 bus.pair_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 bus.pair_ready = 1'b1;
      wait_drain();

      // Reset after four columns; only the fresh block may produce pairs.
      for (int i = 0; i < 64; i++) blk[i] = 12'sd9;
      for (int c = 0; c < 4; c++) send_col(make_col(c));
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("midfill_reset");
      @(posedge clk);
      #1 rst = 1'b0;
      clear_blk();
      blk[27] = 12'sd11;
      push(0, 0, 1, 0, 0);
      push(11, 23, 0, 0, 0);
      push(0, 0, 0, 1, 1);
      send_block();
      wait_drain();

      // Two back-to-back blocks.
      clear_blk();
      blk[0]  = 12'sd5;
      blk[63] = -12'sd3;
      push(5, 0, 1, 0, 0);
      push(-3, 62, 0, 0, 1);
      send_block();
      clear_blk();
      blk[0]  = 12'sd1;
      blk[1]  = 12'sd2;
      blk[16] = -12'sd1;
      push(1, 0, 1, 0, 0);
      push(2, 0, 0, 0, 0);
      push(-1, 1, 0, 0, 0);
      push(0, 0, 0, 1, 1);
      send_block();
      wait_drain();
      check("idle_at_end", bus.pair_valid, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/zigzag_encoder.md
ZIGZAG_ENCODER -- requirements
Module: zigzag_encoder

Interface
REQ-001 SHALL have parameter COEFF_W, default 12: signed coefficient width.
REQ-002 SHALL have port clk_in, input, 1: sole clock; all logic on rising edge.
REQ-003 SHALL have port rst_in, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port column_in, input, 8*COEFF_W: one block column c; slice [COEFF_W*r +: COEFF_W] holds row r.
REQ-005 SHALL have port valid_in, input, 1: column_in valid; a column is accepted when valid_in && ready_out.
REQ-006 SHALL have port ready_out, input-side, output, 1: encoder can accept a column.
REQ-007 SHALL have port value_out, output, COEFF_W signed: coefficient of the current pair.
REQ-008 SHALL have port run_out, output, 6: zero coefficients skipped before value_out in zigzag order.
REQ-009 SHALL have port dc_out, output, 1: pair is the block's DC term (zigzag index 0).
REQ-010 SHALL have port eob_out, output, 1: pair is end-of-block (run 0, value 0).
REQ-011 SHALL have ports valid_out, output, 1, and ready_in, input, 1: a pair transfers when both are high.

Function
REQ-012 SHALL accept columns c = 0..7 in arrival order into a 64-entry block buffer at [r][c].
REQ-013 SHALL scan the buffer in JPEG zigzag order, index 0..63, visiting at most one index per cycle.
REQ-014 SHALL always emit index 0 as a pair with run_out = 0 and dc_out = 1, even when the value is zero.
REQ-015 SHALL, for indices 1..63, count zeros into a run counter and emit a pair with the run when a nonzero coefficient is met; the counter then clears.
REQ-016 SHALL, if index 63 is zero after the scan, emit one pair with eob_out = 1, value 0, run 0; no EOB when index 63 is nonzero.
REQ-017 SHALL use FSM states FILL, SCAN and EOB. FILL->SCAN on the 8th column accepted. SCAN->EOB after index 63 is zero. SCAN->FILL after index 63 is nonzero and its pair is transferred. EOB->FILL when the EOB pair is transferred.
REQ-018 SHALL present the DC pair with valid_out high on the cycle after the 8th column is accepted.
REQ-019 SHALL hold value_out, run_out, dc_out, eob_out and valid_out stable while valid_out && !ready_in, freezing the scan index.
REQ-020 SHALL sustain one pair per cycle when ready_in is held high; a block of all nonzero coefficients emits 64 pairs in 64 consecutive cycles.
REQ-021 SHALL keep run_out at or below 62; no ZRL symbols are generated.
REQ-022 SHALL ignore valid_in when ready_out is low.

Reset
REQ-023 SHALL, while rst_in is high, force state FILL, column count 0, scan index 0, run 0, valid_out 0, dc_out 0, eob_out 0, value_out 0, run_out 0, and ready_out 1 on the following cycle.
REQ-024 SHALL discard any partial block or in-progress scan on reset and emit no further pairs from it.

Configuration
REQ-025 SHALL support macro ZIGZAG_ENCODER_DOUBLE_BUFFER_EN.
- Defined: two ping-pong block buffers; ready_out stays high during SCAN/EOB while the idle buffer is not full; the next block's scan starts the cycle after the current EOB/last pair transfers.
- Undefined: one buffer; ready_out is high only in FILL.

Structure
REQ-026 SHALL take the 64-entry zigzag-to-(row,col) table, the COEFF_W default and the coefficient typedef from the shared jpeg package used by zigzag_decoder.
REQ-027 SHALL isolate the zigzag index mapping in a combinational sub-module zigzag_lut (6-bit index in, 3-bit row and 3-bit column out).

Verification
REQ-028 SHALL verify: all-zero block, ready_in = 1 -> pairs (dc, 0, run 0) then (eob, 0, 0); valid_out then low.
REQ-029 SHALL verify: only [0][0] = 5 and [7][7] = -3 -> pairs (dc, 5, 0) then (-3, run 62), with no EOB.
REQ-030 SHALL verify: [0][0] = 1, [0][1] = 2, [2][0] = -1 -> pairs (dc, 1), (2, run 0), (-1, run 1), then EOB.
REQ-031 SHALL verify: ready_in toggled 1-0-0-1 mid-scan -> outputs held during the low cycles; pair sequence identical to the unstalled run.
REQ-032 SHALL verify: rst_in pulsed after 4 columns, then a fresh 8-column block -> only the fresh block's pairs appear.
REQ-033 SHALL verify: two back-to-back blocks with the macro defined -> second block's DC pair appears the cycle after the first block's final transfer; without the macro, ready_out stays low throughout the first block's scan.
